// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the dual-PE data-memory arbiter: FSM states, PE ids, counter width.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam logic PE1 = 1'b0;
  localparam logic PE2 = 1'b1;

  // Latency counter width; MEM_LAT is limited to 1..4 so two bits suffice.
  localparam int CNT_W = 2;

  // One-hot grant vector for a winner id (bit 0 = PE1, bit 1 = PE2).
  function automatic logic [1:0] id_to_onehot(input logic id);
    return (id == PE2) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin picker. Holds the rr pointer; a lone requester always wins,
// a tie goes to the PE the pointer names, and every taken grant points the
// pointer at the PE that lost (or did not ask).
module rr_arbiter2
  import dmem_arbiter_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid1,
  input  logic       i_valid2,
  input  logic       i_take,
  output logic [1:0] o_grant,
  output logic       o_id
);

  logic r_ptr;
  logic w_id;

  // Winner selection: single requester wins outright, tie resolved by r_ptr.
  always_comb begin
    w_id    = PE1;
    o_grant = 2'b00;
    if (i_valid1 && i_valid2) begin
      w_id = r_ptr;
    end else if (i_valid2) begin
      w_id = PE2;
    end
    if (i_valid1 || i_valid2) begin
      o_grant = id_to_onehot(w_id);
    end
  end

  assign o_id = w_id;

  // Pointer moves to the non-granted PE whenever a grant is taken.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr <= PE1;
    end else if (i_take) begin
      r_ptr <= ~w_id;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between PE1 and PE2. Each transaction runs
// IDLE (accept) -> ISSUE (mem strobe) -> WAIT (MEM_LAT cycles) -> IDLE, with a
// one-cycle response pulse to the owner in the IDLE cycle that follows WAIT.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  input  logic              req2_valid,
  input  logic              req2_we,
  input  logic [ADDR_W-1:0] req2_addr,
  input  logic [DATA_W-1:0] req2_wdata,
  output logic              req2_ready,
  output logic              rsp2_valid,
  output logic [DATA_W-1:0] rsp2_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_id
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

  state_e           r_state;
  state_e           w_next;
  logic             w_take;
  logic [1:0]       w_grant;
  logic             w_win;
  logic             r_we;
  logic [CNT_W-1:0] r_cnt;

  rr_arbiter2 u_rr (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .i_valid1 (req1_valid),
    .i_valid2 (req2_valid),
    .i_take   (w_take),
    .o_grant  (w_grant),
    .o_id     (w_win)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and the combinational ready handshake (IDLE only, never during reset).
  always_comb begin
    w_next     = r_state;
    w_take     = 1'b0;
    req1_ready = 1'b0;
    req2_ready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rst && (w_grant != 2'b00)) begin
          w_take     = 1'b1;
          req1_ready = w_grant[0];
          req2_ready = w_grant[1];
          w_next     = ST_ISSUE;
        end
      end
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT:  if (r_cnt == LAST_CNT) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  assign busy = (r_state != ST_IDLE);

  // Request latch into the registered memory port, latency counter and response registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      r_we       <= 1'b0;
      grant_id   <= PE1;
      r_cnt      <= '0;
      rsp1_valid <= 1'b0;
      rsp2_valid <= 1'b0;
      rsp1_rdata <= '0;
      rsp2_rdata <= '0;
    end else begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp2_valid <= 1'b0;
      if (w_take) begin
        mem_en    <= 1'b1;
        mem_we    <= w_win ? req2_we    : req1_we;
        mem_addr  <= w_win ? req2_addr  : req1_addr;
        mem_wdata <= w_win ? req2_wdata : req1_wdata;
        r_we      <= w_win ? req2_we    : req1_we;
        grant_id  <= w_win;
      end
      if (r_state == ST_ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == ST_WAIT) begin
        if (r_cnt == LAST_CNT) begin
          if (grant_id == PE1) begin
            rsp1_valid <= 1'b1;
            rsp1_rdata <= r_we ? '0 : mem_rdata;
          end else begin
            rsp2_valid <= 1'b1;
            rsp2_rdata <= r_we ? '0 : mem_rdata;
          end
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: MEM_LAT=1 instance driven by per-PE request queues
// with a response scoreboard, plus a MEM_LAT=3 instance for latency timing.
module tb_dmem_arbiter;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        pe;
    logic [31:0] rdata;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b0;

  // MEM_LAT=1 instance signals
  logic        req1_valid = 0, req1_we = 0, req2_valid = 0, req2_we = 0;
  logic [31:0] req1_addr = 0, req1_wdata = 0, req2_addr = 0, req2_wdata = 0;
  logic        req1_ready, req2_ready, rsp1_valid, rsp2_valid;
  logic [31:0] rsp1_rdata, rsp2_rdata;
  logic        mem_en, mem_we, busy, grant_id;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  // MEM_LAT=3 instance signals
  logic        b_req1_valid = 0, b_req1_we = 0, b_req2_valid = 0, b_req2_we = 0;
  logic [31:0] b_req1_addr = 0, b_req1_wdata = 0, b_req2_addr = 0, b_req2_wdata = 0;
  logic        b_req1_ready, b_req2_ready, b_rsp1_valid, b_rsp2_valid;
  logic [31:0] b_rsp1_rdata, b_rsp2_rdata;
  logic        b_mem_en, b_mem_we, b_busy, b_grant_id;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .req2_valid(req2_valid), .req2_we(req2_we), .req2_addr(req2_addr), .req2_wdata(req2_wdata),
    .req2_ready(req2_ready), .rsp2_valid(rsp2_valid), .rsp2_rdata(rsp2_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
  );

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req1_valid(b_req1_valid), .req1_we(b_req1_we), .req1_addr(b_req1_addr), .req1_wdata(b_req1_wdata),
    .req1_ready(b_req1_ready), .rsp1_valid(b_rsp1_valid), .rsp1_rdata(b_rsp1_rdata),
    .req2_valid(b_req2_valid), .req2_we(b_req2_we), .req2_addr(b_req2_addr), .req2_wdata(b_req2_wdata),
    .req2_ready(b_req2_ready), .rsp2_valid(b_rsp2_valid), .rsp2_rdata(b_rsp2_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy), .grant_id(b_grant_id)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int ld2_cyc = 0;

  req_t q1[$];
  req_t q2[$];
  exp_t sb[$];
  logic gnt_log[$];
  int   acc_log[$];

  // Power-on memory contents as a function of word index.
  function automatic logic [31:0] init_word(input logic [5:0] i);
    case (i)
      6'd4:    return 32'hDEADBEEF;
      6'd5:    return 32'h11112222;
      6'd12:   return 32'hCAFE0003;
      default: return 32'h1000_0000 | {26'd0, i};
    endcase
  endfunction

  // Memory models: written words tracked by a flag, unwritten words read the init pattern.
  logic [31:0] mem_a [0:63];
  bit          wr_a  [0:63];
  logic [31:0] mem_b [0:63];
  bit          wr_b  [0:63];
  logic [31:0] b_p0, b_p1;
  logic [31:0] sh    [0:63];
  bit          sh_wr [0:63];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem_a[mem_addr[7:2]] <= mem_wdata;
        wr_a[mem_addr[7:2]]  <= 1'b1;
      end
      mem_rdata <= wr_a[mem_addr[7:2]] ? mem_a[mem_addr[7:2]] : init_word(mem_addr[7:2]);
    end
  end

  always @(posedge clk) begin
    if (b_mem_en) begin
      if (b_mem_we) begin
        mem_b[b_mem_addr[7:2]] <= b_mem_wdata;
        wr_b[b_mem_addr[7:2]]  <= 1'b1;
      end
      b_p0 <= wr_b[b_mem_addr[7:2]] ? mem_b[b_mem_addr[7:2]] : init_word(b_mem_addr[7:2]);
    end
    b_p1        <= b_p0;
    b_mem_rdata <= b_p1;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "watchdog");
  end

  // Expected response for an accepted request, computed from the shadow memory in accept order.
  task automatic record_accept(input logic pe, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata);
    exp_t e;
    e.pe  = pe;
    e.acc = cyc;
    if (we) begin
      e.rdata = 32'h0;
      sh[addr[7:2]]    = wdata;
      sh_wr[addr[7:2]] = 1'b1;
    end else begin
      e.rdata = sh_wr[addr[7:2]] ? sh[addr[7:2]] : init_word(addr[7:2]);
    end
    sb.push_back(e);
    gnt_log.push_back(pe);
    acc_log.push_back(cyc);
  endtask

  // PE drivers and response monitor for the MEM_LAT=1 instance.
  initial begin : drv_a
    exp_t        e;
    req_t        r;
    logic        a1, a2, got_pe;
    logic [31:0] got_d;
    forever begin
      @(negedge clk);
      if (rsp1_valid || rsp2_valid) begin
        tests++;
        if (rsp1_valid && rsp2_valid) begin
          fails++;
          $display("FAIL rsp_exclusive: rsp1_valid=1 rsp2_valid=1, required at most one");
        end else if (sb.size() == 0) begin
          fails++;
          $display("FAIL rsp_unexpected: pulse on pe=%0d at cyc %0d, required none", rsp2_valid, cyc);
        end else begin
          e      = sb.pop_front();
          got_pe = rsp2_valid;
          got_d  = rsp2_valid ? rsp2_rdata : rsp1_rdata;
          if (got_pe !== e.pe || got_d !== e.rdata || cyc !== e.acc + 3 || grant_id !== e.pe) begin
            fails++;
            $display("FAIL rsp_check: pe=%0d rdata=%h cyc=%0d grant_id=%0d, required pe=%0d rdata=%h cyc=%0d grant_id=%0d",
                     got_pe, got_d, cyc, grant_id, e.pe, e.rdata, e.acc + 3, e.pe);
          end
        end
      end
      if (req1_ready === 1'b1 && req2_ready === 1'b1) begin
        tests++;
        fails++;
        $display("FAIL ready_exclusive: both ready at cyc %0d, required at most one", cyc);
      end
      a1 = (req1_valid && req1_ready) === 1'b1;
      a2 = (req2_valid && req2_ready) === 1'b1;
      if (a1) record_accept(1'b0, req1_we, req1_addr, req1_wdata);
      if (a2) record_accept(1'b1, req2_we, req2_addr, req2_wdata);
      @(posedge clk);
      #1;
      if (a1 || !req1_valid) begin
        if (q1.size() > 0) begin
          r = q1.pop_front();
          req1_valid = 1'b1; req1_we = r.we; req1_addr = r.addr; req1_wdata = r.wdata;
        end else begin
          req1_valid = 1'b0;
        end
      end
      if (a2 || !req2_valid) begin
        if (q2.size() > 0) begin
          r = q2.pop_front();
          req2_valid = 1'b1; req2_we = r.we; req2_addr = r.addr; req2_wdata = r.wdata;
          ld2_cyc = cyc;
        end else begin
          req2_valid = 1'b0;
        end
      end
    end
  end

  // Wait for all queued traffic on the MEM_LAT=1 instance to finish.
  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((q1.size() > 0 || q2.size() > 0 || req1_valid || req2_valid || sb.size() > 0 || busy)
           && n < maxc) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    tests++;
    if (n >= maxc) begin
      fails++;
      $display("FAIL drain_timeout: %0d outstanding after %0d cycles, required 0", sb.size(), maxc);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    q1.push_back('{1'b1, 32'h60, 32'h0000_00AB});
    q2.push_back('{1'b0, 32'h64, 32'h0});
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, mem_en, mem_we, rsp1_valid, rsp2_valid, req1_ready, req2_ready, grant_id} !== 8'b0) begin
      fails++;
      $display("FAIL reset_ctrl: busy,en,we,rv1,rv2,rdy1,rdy2,gid=%b, required 00000000",
               {busy, mem_en, mem_we, rsp1_valid, rsp2_valid, req1_ready, req2_ready, grant_id});
    end
    tests++;
    if ({mem_addr, mem_wdata, rsp1_rdata, rsp2_rdata} !== 128'h0) begin
      fails++;
      $display("FAIL reset_data: addr=%h wdata=%h r1=%h r2=%h, required all 0",
               mem_addr, mem_wdata, rsp1_rdata, rsp2_rdata);
    end
    tests++;
    if ({b_busy, b_mem_en, b_rsp1_valid, b_rsp2_valid, b_req1_ready, b_req2_ready, b_grant_id} !== 7'b0) begin
      fails++;
      $display("FAIL reset_lat3: ctrl=%b, required 0000000",
               {b_busy, b_mem_en, b_rsp1_valid, b_rsp2_valid, b_req1_ready, b_req2_ready, b_grant_id});
    end
    gnt_log.delete();
    @(posedge clk); #1 rst = 1'b1;
    drain(40);
    tests++;
    if (gnt_log.size() != 2 || gnt_log[0] !== 1'b0 || gnt_log[1] !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_order: %0d grants first=%0d, required 2 grants PE1 then PE2",
               gnt_log.size(), gnt_log.size() > 0 ? gnt_log[0] : 1'bx);
    end
  endtask

  task automatic test_single_load();
    int t;
    t = -1;
    @(negedge clk);
    q1.push_back('{1'b0, 32'h10, 32'h0});
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req1_ready === 1'b1) begin t = cyc; break; end
    end
    tests++;
    if (t < 0) begin
      fails++;
      $display("FAIL single_ready: ready1 never seen, required within 20 cycles");
    end else begin
      @(negedge clk);
      tests++;
      if ({mem_en, mem_we, busy, rsp1_valid} !== 4'b1010 || mem_addr !== 32'h10) begin
        fails++;
        $display("FAIL single_issue: en,we,busy,rv1=%b addr=%h, required 1010 addr 00000010",
                 {mem_en, mem_we, busy, rsp1_valid}, mem_addr);
      end
      @(negedge clk);
      tests++;
      if ({mem_en, busy, rsp1_valid} !== 3'b010) begin
        fails++;
        $display("FAIL single_wait: en,busy,rv1=%b, required 010", {mem_en, busy, rsp1_valid});
      end
      @(negedge clk);
      tests++;
      if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'hDEADBEEF || rsp2_valid !== 1'b0 || cyc !== t + 3) begin
        fails++;
        $display("FAIL single_rsp: rv1=%b rdata=%h rv2=%b cyc=%0d, required 1 deadbeef 0 cyc %0d",
                 rsp1_valid, rsp1_rdata, rsp2_valid, cyc, t + 3);
      end
      @(negedge clk);
      tests++;
      if (rsp1_valid !== 1'b0 || rsp1_rdata !== 32'hDEADBEEF) begin
        fails++;
        $display("FAIL single_hold: rv1=%b rdata=%h, required 0 deadbeef", rsp1_valid, rsp1_rdata);
      end
    end
    drain(20);
  endtask

  task automatic test_round_robin();
    pulse_reset();
    gnt_log.delete();
    @(negedge clk);
    q1.push_back('{1'b1, 32'h20, 32'h5});
    q2.push_back('{1'b0, 32'h20, 32'h0});
    drain(40);
    tests++;
    if (gnt_log.size() != 2 || gnt_log[0] !== 1'b0 || gnt_log[1] !== 1'b1) begin
      fails++;
      $display("FAIL rr_order: %0d grants first=%0d, required PE1 then PE2",
               gnt_log.size(), gnt_log.size() > 0 ? gnt_log[0] : 1'bx);
    end
    tests++;
    if (rsp1_rdata !== 32'h0 || rsp2_rdata !== 32'h5) begin
      fails++;
      $display("FAIL rr_data: rsp1=%h rsp2=%h, required 0 and 5", rsp1_rdata, rsp2_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_gnt [5];
    exp_gnt = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    gnt_log.delete();
    acc_log.delete();
    @(negedge clk);
    for (int i = 0; i < 3; i++) q1.push_back('{1'b0, 32'h40 + 32'(4 * i), 32'h0});
    for (int i = 0; i < 2; i++) q2.push_back('{1'b0, 32'h80 + 32'(4 * i), 32'h0});
    drain(80);
    tests++;
    if (gnt_log.size() != 5) begin
      fails++;
      $display("FAIL b2b_count: %0d grants, required 5", gnt_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests++;
        if (gnt_log[i] !== exp_gnt[i]) begin
          fails++;
          $display("FAIL b2b_grant[%0d]: got PE id %0d, required %0d", i, gnt_log[i], exp_gnt[i]);
        end
      end
      for (int i = 1; i < 5; i++) begin
        tests++;
        if (acc_log[i] - acc_log[i-1] != 3) begin
          fails++;
          $display("FAIL b2b_spacing[%0d]: gap %0d cycles, required 3", i, acc_log[i] - acc_log[i-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int t;
    t = -1;
    @(negedge clk);
    q1.push_back('{1'b0, 32'h14, 32'h0});
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req1_ready === 1'b1) begin t = cyc; break; end
    end
    tests++;
    if (t < 0) begin
      fails++;
      $display("FAIL midrst_ready: ready1 never seen, required within 20 cycles");
    end else begin
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      sb.delete();
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      tests++;
      if ({busy, mem_en, rsp1_valid, rsp2_valid} !== 4'b0 || rsp1_rdata !== 32'h0) begin
        fails++;
        $display("FAIL midrst_state: busy,en,rv1,rv2=%b rdata1=%h, required 0000 and 0",
                 {busy, mem_en, rsp1_valid, rsp2_valid}, rsp1_rdata);
      end
      for (int n = 0; n < 4; n++) begin
        @(negedge clk);
        tests++;
        if (rsp1_valid !== 1'b0 || rsp2_valid !== 1'b0) begin
          fails++;
          $display("FAIL midrst_no_rsp: rv1=%b rv2=%b, required 0 0", rsp1_valid, rsp2_valid);
        end
      end
    end
    gnt_log.delete();
    q1.push_back('{1'b0, 32'h14, 32'h0});
    q2.push_back('{1'b1, 32'h50, 32'h7});
    drain(40);
    tests++;
    if (gnt_log.size() != 2 || gnt_log[0] !== 1'b0 || rsp1_rdata !== 32'h11112222) begin
      fails++;
      $display("FAIL midrst_after: %0d grants first=%0d rdata1=%h, required 2 grants PE1 first 11112222",
               gnt_log.size(), gnt_log.size() > 0 ? gnt_log[0] : 1'bx, rsp1_rdata);
    end
  endtask

  task automatic test_only_pe2();
    int t;
    t = -1;
    @(negedge clk);
    q2.push_back('{1'b0, 32'h50, 32'h0});
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req2_ready === 1'b1) begin t = cyc; break; end
    end
    tests++;
    if (t < 0 || t != ld2_cyc || req1_ready !== 1'b0) begin
      fails++;
      $display("FAIL pe2_immediate: accept cyc %0d ready1=%b, required cyc %0d ready1 0",
               t, req1_ready, ld2_cyc);
    end
    drain(20);
    tests++;
    if (rsp2_rdata !== 32'h7) begin
      fails++;
      $display("FAIL pe2_data: rsp2=%h, required 00000007", rsp2_rdata);
    end
    gnt_log.delete();
    q1.push_back('{1'b0, 32'h90, 32'h0});
    q2.push_back('{1'b0, 32'h94, 32'h0});
    drain(40);
    tests++;
    if (gnt_log.size() != 2 || gnt_log[0] !== 1'b0) begin
      fails++;
      $display("FAIL pe2_ptr: first grant %0d, required PE1 (0)", gnt_log.size() > 0 ? gnt_log[0] : 1'bx);
    end
  endtask

  task automatic test_lat3();
    int t, t1;
    t = -1;
    t1 = -1;
    @(posedge clk);
    #1 b_req2_valid = 1'b1; b_req2_we = 1'b0; b_req2_addr = 32'h30;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (b_req2_ready === 1'b1) begin t = cyc; break; end
    end
    @(posedge clk);
    #1 b_req2_valid = 1'b0;
    tests++;
    if (t < 0) begin
      fails++;
      $display("FAIL lat3_ready: ready2 never seen, required within 20 cycles");
    end else begin
      @(negedge clk);
      tests++;
      if (b_mem_en !== 1'b1 || b_mem_addr !== 32'h30 || b_mem_we !== 1'b0) begin
        fails++;
        $display("FAIL lat3_issue: en=%b we=%b addr=%h, required 1 0 00000030", b_mem_en, b_mem_we, b_mem_addr);
      end
      repeat (3) @(negedge clk);
      tests++;
      if (b_rsp2_valid !== 1'b0 || b_busy !== 1'b1 || b_mem_en !== 1'b0) begin
        fails++;
        $display("FAIL lat3_early: rv2=%b busy=%b en=%b at t+4, required 0 1 0", b_rsp2_valid, b_busy, b_mem_en);
      end
      @(posedge clk);
      #1 b_req1_valid = 1'b1; b_req1_we = 1'b1; b_req1_addr = 32'h34; b_req1_wdata = 32'h9;
      @(negedge clk);
      tests++;
      if (b_rsp2_valid !== 1'b1 || b_rsp2_rdata !== 32'hCAFE0003 || b_req1_ready !== 1'b1 || cyc !== t + 5) begin
        fails++;
        $display("FAIL lat3_rsp: rv2=%b rdata=%h rdy1=%b cyc=%0d, required 1 cafe0003 1 cyc %0d",
                 b_rsp2_valid, b_rsp2_rdata, b_req1_ready, cyc, t + 5);
      end
      @(posedge clk);
      #1 b_req1_valid = 1'b0;
      for (int n = 0; n < 12; n++) begin
        @(negedge clk);
        if (b_rsp1_valid === 1'b1) begin t1 = cyc; break; end
      end
      tests++;
      if (t1 != t + 10 || b_rsp1_rdata !== 32'h0 || mem_b[13] !== 32'h9) begin
        fails++;
        $display("FAIL lat3_store: rsp1 cyc %0d rdata=%h mem=%h, required cyc %0d rdata 0 mem 00000009",
                 t1, b_rsp1_rdata, mem_b[13], t + 10);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_round_robin();
    test_back_to_back();
    test_reset_mid_wait();
    test_only_pe2();
    test_lat3();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
